// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write ports,
// reserve request, ready flag and debug read.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en_i;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic [1:0]               wr_en_i;
    logic [2*ADDR_W-1:0]      wr_addr_i;
    logic [2*DATA_W-1:0]      wr_data_i;
    logic                     rsv_en_i;
    logic [ADDR_W-1:0]        rsv_addr_i;
    logic                     ready_o;
    logic [ADDR_W-1:0]        dbg_addr_i;
    logic [DATA_W-1:0]        dbg_data_o;

    modport master (
        output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               rsv_en_i, rsv_addr_i, dbg_addr_i,
        input  rd_data_o, rd_busy_o, ready_o, dbg_data_o
    );

    modport slave (
        input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
               rsv_en_i, rsv_addr_i, dbg_addr_i,
        output rd_data_o, rd_busy_o, ready_o, dbg_data_o
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port GPR file for the decode stage: NUM_RD forwarding read ports,
// two write ports (port 1 wins), a per-register busy scoreboard, and a
// post-reset clear sequence that zeroes entries 1..DEPTH-1 one per cycle.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DEPTH-1:0]  busy;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic [ADDR_W-1:0] wa [2];
    logic [DATA_W-1:0] wd [2];

    assign ready       = (state == S_READY);
    assign bus.ready_o = ready;
    assign wa[0]       = bus.wr_addr_i[0 +: ADDR_W];
    assign wa[1]       = bus.wr_addr_i[ADDR_W +: ADDR_W];
    assign wd[0]       = bus.wr_data_i[0 +: DATA_W];
    assign wd[1]       = bus.wr_data_i[DATA_W +: DATA_W];

    // Clear-sequence FSM: walk clr_ptr from 1 to DEPTH-1, then go READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_CLEAR;
            clr_ptr <= ADDR_W'(1);
        end else if (state == S_CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
            if (clr_ptr == '1) begin
                state <= S_READY;
            end
        end
    end

    // Array storage: zero fill during CLEAR, port writes in READY (port 1 last so it wins).
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == S_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else begin
                if (bus.wr_en_i[0] && wa[0] != '0) begin
                    mem[wa[0]] <= wd[0];
                end
                if (bus.wr_en_i[1] && wa[1] != '0) begin
                    mem[wa[1]] <= wd[1];
                end
            end
        end
    end

    // Busy scoreboard: writes retire a producer, a reserve issued on the same edge re-arms it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else if (state == S_READY) begin
            if (bus.wr_en_i[0]) begin
                busy[wa[0]] <= 1'b0;
            end
            if (bus.wr_en_i[1]) begin
                busy[wa[1]] <= 1'b0;
            end
            if (bus.rsv_en_i && bus.rsv_addr_i != '0) begin
                busy[bus.rsv_addr_i] <= 1'b1;
            end
            busy[0] <= 1'b0;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic              hit1;
            logic              hit0;
            logic              live;

            assign ra   = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
            assign hit1 = bus.wr_en_i[1] && (wa[1] == ra);
            assign hit0 = bus.wr_en_i[0] && (wa[0] == ra);
            assign live = ready && bus.rd_en_i[k] && (ra != '0);

            // Forwarding mux: in-flight port 1, then port 0, then stored entry.
            assign bus.rd_data_o[k*DATA_W +: DATA_W] =
                !live ? '0 :
                hit1  ? wd[1] :
                hit0  ? wd[0] :
                        mem[ra];

            // A producer writing this cycle satisfies the dependency immediately.
            assign bus.rd_busy_o[k] = live && busy[ra] && !(hit0 || hit1);
        end
    endgenerate

    assign bus.dbg_data_o = (ready && bus.dbg_addr_i != '0) ? mem[bus.dbg_addr_i] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sequence timing, forwarding, write
// priority, r0 handling, busy scoreboard and reset during the clear sequence.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        rsv;
        logic [4:0]  ra;
        logic [1:0]  re;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [4:0]  da;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic [31:0] ed;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(
        input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1,
        input logic rsv, input logic [4:0] ra,
        input logic [1:0] re, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] da,
        input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb, input logic [31:0] ed);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.rsv = rsv; v.ra = ra; v.re = re; v.r0 = r0; v.r1 = r1; v.da = da;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_en_i    = '0;
        bus.rd_addr_i  = '0;
        bus.wr_en_i    = '0;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = '0;
        bus.rsv_en_i   = 1'b0;
        bus.rsv_addr_i = '0;
        bus.dbg_addr_i = '0;
    endtask

    // Release reset and count edges until ready_o rises (bounded).
    task automatic count_clear(input string name, input bit poke_write);
        int n;
        logic done;
        n = 0;
        done = 1'b0;
        rst = 1'b1;
        while (!done && n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.ready_o) done = 1'b1;
            if (poke_write && n == 5) begin
                bus.rd_en_i   = 2'b11;
                bus.rd_addr_i = {5'd9, 5'd9};
                bus.dbg_addr_i = 5'd9;
                #1;
                chk("clear_rd0", bus.rd_data_o[31:0], 32'h0);
                chk("clear_busy", {30'd0, bus.rd_busy_o}, 32'h0);
                chk("clear_dbg", bus.dbg_data_o, 32'h0);
            end
            if (poke_write && n == 20) begin
                bus.wr_en_i    = 2'b01;
                bus.wr_addr_i  = {5'd0, 5'd5};
                bus.wr_data_i  = {32'h0, 32'h0000_1234};
                bus.rsv_en_i   = 1'b1;
                bus.rsv_addr_i = 5'd5;
            end
            if (poke_write && n == 21) idle_inputs();
        end
        chk(name, n, 31);
    endtask

    initial begin
        vt[0]  = mk(2'b01, 5,  32'hDEADBEEF, 0, 0,    0, 0, 2'b11, 5,  6,  5,  32'hDEADBEEF, 0, 2'b00, 0);
        vt[1]  = mk(2'b00, 0,  0, 0, 0,               0, 0, 2'b11, 5,  0,  5,  32'hDEADBEEF, 0, 2'b00, 32'hDEADBEEF);
        vt[2]  = mk(2'b11, 7,  32'h11, 7, 32'h22,     0, 0, 2'b11, 7,  5,  7,  32'h22, 32'hDEADBEEF, 2'b00, 0);
        vt[3]  = mk(2'b00, 0,  0, 0, 0,               0, 0, 2'b01, 7,  7,  7,  32'h22, 0, 2'b00, 32'h22);
        vt[4]  = mk(2'b11, 0,  32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0);
        vt[5]  = mk(2'b00, 0,  0, 0, 0,               0, 0, 2'b11, 0,  0,  0,  0, 0, 2'b00, 0);
        vt[6]  = mk(2'b00, 0,  0, 0, 0,               1, 9, 2'b11, 9,  9,  9,  0, 0, 2'b00, 0);
        vt[7]  = mk(2'b00, 0,  0, 0, 0,               0, 0, 2'b11, 9,  9,  9,  0, 0, 2'b11, 0);
        vt[8]  = mk(2'b01, 9,  32'h5, 0, 0,           0, 0, 2'b11, 9,  9,  9,  32'h5, 32'h5, 2'b00, 0);
        vt[9]  = mk(2'b00, 0,  0, 0, 0,               0, 0, 2'b11, 9,  9,  9,  32'h5, 32'h5, 2'b00, 32'h5);
        vt[10] = mk(2'b10, 0,  0, 9, 32'h6,           1, 9, 2'b11, 9,  9,  9,  32'h6, 32'h6, 2'b00, 32'h5);
        vt[11] = mk(2'b00, 0,  0, 0, 0,               0, 0, 2'b11, 9,  9,  9,  32'h6, 32'h6, 2'b11, 32'h6);
        vt[12] = mk(2'b11, 10, 32'h8, 9, 32'h7,       0, 0, 2'b11, 10, 9,  10, 32'h8, 32'h7, 2'b00, 0);
        vt[13] = mk(2'b00, 0,  0, 0, 0,               0, 0, 2'b11, 10, 9,  9,  32'h8, 32'h7, 2'b00, 32'h7);
        vt[14] = mk(2'b01, 4,  32'h1, 0, 0,           1, 3, 2'b11, 3,  4,  3,  0, 32'h1, 2'b00, 0);
        vt[15] = mk(2'b00, 0,  0, 0, 0,               0, 0, 2'b11, 3,  4,  4,  0, 32'h1, 2'b01, 32'h1);
        vt[16] = mk(2'b00, 0,  0, 0, 0,               0, 0, 2'b10, 3,  3,  3,  0, 0, 2'b10, 0);

        // Reset state with an active read request.
        idle_inputs();
        rst = 1'b0;
        bus.rd_en_i    = 2'b11;
        bus.rd_addr_i  = {5'd4, 5'd3};
        bus.dbg_addr_i = 5'd3;
        tick();
        tick();
        chk("rst_ready", {31'd0, bus.ready_o}, 32'h0);
        chk("rst_rd0", bus.rd_data_o[31:0], 32'h0);
        chk("rst_rd1", bus.rd_data_o[63:32], 32'h0);
        chk("rst_busy", {30'd0, bus.rd_busy_o}, 32'h0);
        chk("rst_dbg", bus.dbg_data_o, 32'h0);
        idle_inputs();

        count_clear("clear_edges", 1'b0);

        for (int a = 1; a < 32; a++) begin
            bus.dbg_addr_i = 5'(a);
            #1;
            chk($sformatf("dbg_zero_r%0d", a), bus.dbg_data_o, 32'h0);
        end

        for (int i = 0; i < 17; i++) begin
            bus.wr_en_i    = vt[i].we;
            bus.wr_addr_i  = {vt[i].wa1, vt[i].wa0};
            bus.wr_data_i  = {vt[i].wd1, vt[i].wd0};
            bus.rsv_en_i   = vt[i].rsv;
            bus.rsv_addr_i = vt[i].ra;
            bus.rd_en_i    = vt[i].re;
            bus.rd_addr_i  = {vt[i].r1, vt[i].r0};
            bus.dbg_addr_i = vt[i].da;
            #1;
            chk($sformatf("v%0d_rd0", i), bus.rd_data_o[31:0], vt[i].e0);
            chk($sformatf("v%0d_rd1", i), bus.rd_data_o[63:32], vt[i].e1);
            chk($sformatf("v%0d_busy", i), {30'd0, bus.rd_busy_o}, {30'd0, vt[i].eb});
            chk($sformatf("v%0d_dbg", i), bus.dbg_data_o, vt[i].ed);
            tick();
        end
        idle_inputs();

        // Reset again, then interrupt the clear sequence after 10 steps.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int s = 0; s < 10; s++) tick();
        chk("mid_clear_ready", {31'd0, bus.ready_o}, 32'h0);
        rst = 1'b0;
        tick();
        chk("restart_ready", {31'd0, bus.ready_o}, 32'h0);
        count_clear("restart_edges", 1'b1);

        bus.dbg_addr_i = 5'd5;
        bus.rd_en_i    = 2'b11;
        bus.rd_addr_i  = {5'd3, 5'd5};
        #1;
        chk("clear_write_dropped", bus.dbg_data_o, 32'h0);
        chk("clear_rsv_dropped", {31'd0, bus.rd_busy_o[0]}, 32'h0);
        chk("busy_reset_r3", {31'd0, bus.rd_busy_o[1]}, 32'h0);
        bus.dbg_addr_i = 5'd9;
        #1;
        chk("recleared_r9", bus.dbg_data_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
